bus_capture: RTL and testbench
==============================

# bus_capture

Downstream consumer of the shared tri-state data bus whose two drivers are enabled by the `oe[1:0]` output of the bus output-enable selector. It watches `oe` and samples the bus once per driver-enable window, after a one-cycle settle, and pushes `{source, data}` into a small first-word-fall-through (FWFT) FIFO. It presents that FIFO on a valid/ready stream and flags enable contention and FIFO overflow.

## Interface
- `DATA_W`, default 8: bus and output data width.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock; all inputs are synchronous to it.
- `rst_n` in 1: asynchronous, active-low reset.
- `oe` in 2: driver enables from the selector; bit 0 is source 0, bit 1 is source 1.
- `bus` in DATA_W: resolved shared bus value.
- `out_data` out DATA_W: FIFO head data.
- `out_src` out 1: FIFO head source id (0 for `oe[0]`, 1 for `oe[1]`).
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts the head when `out_valid` is high.
- `count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky; a capture was dropped because the FIFO was full.
- `contention` out 1: sticky; `oe==2'b11` was observed.

## Operation
Capture FSM, registered, one state per window:
- **IDLE**: `oe==00`.
  - `oe==01` or `oe==10`: go to SETTLE and latch the source id.
  - `oe==11`: go to FAULT.
- **SETTLE**: first cycle of a window. The bus is not sampled.
  - `oe` equal to the latched value: go to CAPTURE.
  - `oe==00`: go to IDLE. This is a short window: no capture, no flag.
  - Other single-bit `oe`: restart SETTLE with the new source.
  - `oe==11`: go to FAULT.
- **CAPTURE**: this is a transient action on the SETTLE→CAPTURE edge. The capture edge samples `bus` and pushes `{src, bus}`. The state then behaves as HOLD.
- **HOLD**: wait for `oe` to change.
  - `oe==00`: go to IDLE.
  - Different single-bit `oe`: go to SETTLE with the new source. The selector never does this, but it must be handled.
  - `oe==11`: go to FAULT.
- **FAULT**: set `contention`. No captures. Leave to IDLE only when `oe==00`.

The rule is exactly one capture per window, and only when the window lasts ≥2 consecutive cycles of the same single-bit `oe`.

FIFO:
- Head is exposed combinationally from the storage array.
- `out_valid = (count!=0)`.
- Pop occurs when `out_valid && out_ready`.
- Push occurs on capture. If `count==DEPTH` and there is no pop in the same cycle, the entry is dropped and `overflow` is set.
- Simultaneous push and pop:
  - When full: both are accepted and `count` is unchanged.
  - When empty: push only. Pop is not possible because `out_valid` is 0.
- Read and write pointers wrap modulo DEPTH.
- `out_data`/`out_src` are don't-care when `out_valid==0`, but they must not be X after reset.

Reset (async assert, synchronous deassert assumed upstream):
- FSM goes to IDLE and the FIFO empties.
- All outputs reset to 0: `out_data`, `out_src`, `out_valid`, `count`, `overflow`, `contention`.
- `overflow` and `contention` clear only on reset.
- If `oe` is non-zero at reset release, that window is treated as new and enters SETTLE at the first edge.

## Timing
- Let edge E be the first rising edge sampling a non-zero single-bit `oe`. The FSM is in SETTLE after E.
- At edge E+1, if `oe` is unchanged, `bus` as presented before E+1 is written. `count` increments and `out_valid` rises after E+1.
- Bus-to-`out_valid` latency is 1 cycle from the sampled cycle; the window-start-to-`out_valid` latency is 2 edges.
- Pop takes effect at the edge where `out_valid && out_ready`; the next head is visible after that edge.
- `out_valid` is combinational on `count` only, never on `out_ready`.
- Flags assert the cycle after the causing edge.

## Test plan
- **Normal alternation**: drive oe sequence 01,01,01,00,10,10,00 with bus=0xA5 during the 01 window and 0x3C during the 10 window, `out_ready=1`. Outputs must be {0,0xA5} then {1,0x3C}, each appearing 2 edges after window start; `count` never exceeds 1.
- **Short window**: drive oe=01 for 1 cycle then 00, with bus=0x11. No push; `count` stays 0; no flags.
- **Overflow**: `out_ready=0`, DEPTH=4, five 3-cycle windows with data 1..5. `count==4`, head=1, `overflow==1`. After draining, data 1,2,3,4 come out in order; 5 is lost.
- **Full simultaneous push/pop**: FIFO full, `out_ready=1` on the capture edge. `count` stays at 4, `overflow` stays 0, and the new entry is last out.
- **Contention**: drive oe=11 for 2 cycles, then 01 (no capture, still FAULT), then 00, then a valid 01 window. `contention==1`; only the last window is captured.
- **Reset mid-window**: assert `rst_n=0` during HOLD with `count==2`. All outputs are 0 immediately (async). After release with oe=10 held, the capture occurs at the 2nd edge after release.

Source files
------------

// File: rtl/bus_capture.sv
// Samples the shared tri-state bus once per driver-enable window (after a one-cycle settle)
// and queues {source, data} in a first-word-fall-through FIFO on a valid/ready stream.
//
//   state  | meaning
//   IDLE   | no driver enabled
//   SETTLE | first cycle of a window, bus not yet stable
//   HOLD   | window already captured, waiting for oe to change
//   FAULT  | both drivers enabled, no captures until oe returns to 00
module bus_capture #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               oe,
  input  logic [DATA_W-1:0]        bus,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_src,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     contention
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD, FAULT} state_t;

  state_t state, state_nxt;
  logic   src, src_nxt;
  logic   capture;
  logic   single, same;

  assign single = oe[0] ^ oe[1];
  assign same   = single && (oe[1] == src);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      src   <= 1'b0;
    end else begin
      state <= state_nxt;
      src   <= src_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (oe == 2'b11) begin
          state_nxt = FAULT;
        end else if (single) begin
          state_nxt = SETTLE;
          src_nxt   = oe[1];
        end
      end
      SETTLE: begin
        if (oe == 2'b11) begin
          state_nxt = FAULT;
        end else if (oe == 2'b00) begin
          state_nxt = IDLE;
        end else if (same) begin
          state_nxt = HOLD;
          capture   = 1'b1;
        end else begin
          state_nxt = SETTLE;
          src_nxt   = oe[1];
        end
      end
      HOLD: begin
        if (oe == 2'b11) begin
          state_nxt = FAULT;
        end else if (oe == 2'b00) begin
          state_nxt = IDLE;
        end else if (!same) begin
          state_nxt = SETTLE;
          src_nxt   = oe[1];
        end
      end
      FAULT: begin
        if (oe == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            pop, full, wr_en;

  assign full  = (count == CW'(DEPTH));
  assign pop   = out_valid && out_ready;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign wr_en = capture && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      contention <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {src, bus};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (capture && full && !pop) overflow <= 1'b1;
      if (oe == 2'b11) contention <= 1'b1;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr][DATA_W-1:0];
  assign out_src   = mem[rd_ptr][DATA_W];

endmodule

// File: tb/tb_bus_capture.sv
// Bench for bus_capture: directed scenarios then randomized oe/bus/ready traffic,
// each cycle compared against a window-length / queue reference model.
module tb_bus_capture;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        oe = 2'b00;
  logic [DATA_W-1:0] bus = '0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_valid;
  logic [$clog2(DEPTH):0] count;
  logic              overflow;
  logic              contention;

  bus_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .oe(oe), .bus(bus),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .overflow(overflow),
    .contention(contention)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W:0] q[$];
  bit         m_ovf, m_con, m_fault;
  logic [1:0] m_prev;
  int         m_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_con = 0; m_fault = 0;
    m_prev = 2'b00; m_run = 0;
  endtask

  // A window captures exactly when it reaches its 2nd consecutive cycle of the same
  // single-bit oe, unless both-enabled was seen and oe has not yet returned to 00.
  task automatic model_edge(input logic [1:0] o, input logic [DATA_W-1:0] b, input logic r);
    bit single, cap, pop;
    int sz;
    single = (o == 2'b01) || (o == 2'b10);
    if (o == 2'b11) begin
      m_fault = 1; m_con = 1;
    end else if (o == 2'b00) begin
      m_fault = 0;
    end
    if (single && o == m_prev) m_run++;
    else m_run = single ? 1 : 0;
    cap = !m_fault && (m_run == 2);
    sz  = q.size();
    pop = (sz != 0) && r;
    if (pop) void'(q.pop_front());
    if (cap) begin
      if (sz == DEPTH && !pop) m_ovf = 1;
      else q.push_back({o[1], b});
    end
    m_prev = o;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, "/count"}, 32'(count), 32'(q.size()));
    check({ctx, "/valid"}, 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check({ctx, "/data"}, 32'(out_data), 32'(q[0][DATA_W-1:0]));
      check({ctx, "/src"}, 32'(out_src), 32'(q[0][DATA_W]));
    end
    check({ctx, "/overflow"}, 32'(overflow), 32'(m_ovf));
    check({ctx, "/contention"}, 32'(contention), 32'(m_con));
  endtask

  task automatic check_zero(input string ctx);
    check({ctx, "/data"}, 32'(out_data), 32'd0);
    check({ctx, "/src"}, 32'(out_src), 32'd0);
    check({ctx, "/valid"}, 32'(out_valid), 32'd0);
    check({ctx, "/count"}, 32'(count), 32'd0);
    check({ctx, "/overflow"}, 32'(overflow), 32'd0);
    check({ctx, "/contention"}, 32'(contention), 32'd0);
  endtask

  // Called 1 time unit after a rising edge; inputs change mid-cycle.
  task automatic step(input logic [1:0] o, input logic [DATA_W-1:0] b, input logic r,
                      input string ctx);
    oe = o; bus = b; out_ready = r;
    model_edge(o, b, r);
    @(posedge clk);
    #1;
    check_outputs(ctx);
  endtask

  task automatic async_reset(input logic [1:0] o_rel, input string ctx);
    #2;
    rst_n = 1'b0; oe = 2'b00; out_ready = 1'b0;
    #1;
    model_reset();
    check_zero(ctx);
    #2;
    oe = o_rel;
    rst_n = 1'b1;
  endtask

  task automatic window(input logic [1:0] o, input logic [DATA_W-1:0] b, input logic r,
                        input int len, input string ctx);
    for (int i = 0; i < len; i++) step(o, b, r, ctx);
    step(2'b00, '0, r, ctx);
  endtask

  initial begin
    logic [1:0] ro;
    int         hold;
    model_reset();
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // normal alternation
    step(2'b01, 8'hA5, 1'b1, "norm_settle0");
    step(2'b01, 8'hA5, 1'b1, "norm_cap0");
    check("norm_head0", 32'(out_data), 32'h0A5);
    step(2'b01, 8'hA5, 1'b1, "norm_hold0");
    step(2'b00, 8'h00, 1'b1, "norm_idle");
    step(2'b10, 8'h3C, 1'b1, "norm_settle1");
    step(2'b10, 8'h3C, 1'b1, "norm_cap1");
    check("norm_head1", 32'({out_src, out_data}), 32'h13C);
    step(2'b00, 8'h00, 1'b1, "norm_end");

    // short window
    step(2'b01, 8'h11, 1'b1, "short_a");
    step(2'b00, 8'h11, 1'b1, "short_b");
    step(2'b00, 8'h11, 1'b1, "short_c");

    // overflow
    for (int k = 1; k <= 5; k++)
      window((k % 2) ? 2'b01 : 2'b10, 8'(k), 1'b0, 3, "ovf_fill");
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_head", 32'(out_data), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int k = 0; k < 5; k++) step(2'b00, 8'h00, 1'b1, "ovf_drain");

    // full with simultaneous push/pop
    async_reset(2'b00, "rst_fullpp");
    for (int k = 1; k <= 4; k++) window(2'b10, 8'(8'h40 + k), 1'b0, 2, "fpp_fill");
    step(2'b01, 8'h77, 1'b0, "fpp_settle");
    step(2'b01, 8'h77, 1'b1, "fpp_cap");
    check("fpp_count", 32'(count), 32'd4);
    check("fpp_ovf", 32'(overflow), 32'd0);
    step(2'b00, 8'h00, 1'b0, "fpp_idle");
    for (int k = 0; k < 4; k++) step(2'b00, 8'h00, 1'b1, "fpp_drain");

    // contention
    step(2'b11, 8'hEE, 1'b0, "con_a");
    step(2'b11, 8'hEE, 1'b0, "con_b");
    step(2'b01, 8'hEE, 1'b0, "con_fault01");
    step(2'b01, 8'hEE, 1'b0, "con_fault01b");
    step(2'b00, 8'hEE, 1'b0, "con_idle");
    window(2'b01, 8'h5A, 1'b0, 3, "con_win");
    check("con_flag", 32'(contention), 32'd1);
    check("con_count", 32'(count), 32'd1);

    // reset mid-window
    async_reset(2'b00, "rst_pre_mid");
    window(2'b01, 8'h21, 1'b0, 2, "mid_w1");
    step(2'b10, 8'h22, 1'b0, "mid_settle");
    step(2'b10, 8'h22, 1'b0, "mid_cap");
    step(2'b10, 8'h22, 1'b0, "mid_hold");
    check("mid_count2", 32'(count), 32'd2);
    async_reset(2'b10, "rst_mid");
    step(2'b10, 8'h99, 1'b0, "rel_e1");
    check("rel_e1_count", 32'(count), 32'd0);
    step(2'b10, 8'h99, 1'b0, "rel_e2");
    check("rel_e2_count", 32'(count), 32'd1);
    step(2'b00, 8'h00, 1'b1, "rel_drain");

    // randomized traffic
    async_reset(2'b00, "rst_rand");
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 15))
        0, 1, 2, 3, 4, 5:     ro = 2'b00;
        6, 7, 8, 9, 10:       ro = 2'b01;
        11, 12, 13, 14:       ro = 2'b10;
        default:              ro = 2'b11;
      endcase
      hold = $urandom_range(1, 4);
      for (int i = 0; i < hold; i++)
        step(ro, 8'($urandom), 1'($urandom_range(0, 2) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
